// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LINE_SIZE  = 64;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first pending index at or after ptr_i, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [GW-1:0]      ptr_i,
  output logic [GW-1:0]      idx_o,
  output logic               vld_o
);

  logic found;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && pending_i[j] && (GW'(j) >= ptr_i)) begin
        found = 1'b1;
        idx_o = GW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && pending_i[j]) begin
        found = 1'b1;
        idx_o = GW'(j);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between NUM_REQ cache controllers.
// Fully registered outputs; a stalled memory is abandoned after TIMEOUT cycles with req_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_SIZE  = DEF_LINE_SIZE,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 256,
  localparam int LINE_BITS = LINE_SIZE * 8,
  localparam int GW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LINE_BITS-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]            req_read_en,
  input  logic [NUM_REQ-1:0]            req_write_en,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [LINE_BITS-1:0]          req_rdata,
  output logic                          req_err,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [LINE_BITS-1:0]          mem_write_data,
  output logic                          mem_read_en,
  output logic                          mem_write_en,
  input  logic [LINE_BITS-1:0]          mem_read_data,
  input  logic                          mem_ready,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0]  wdata_q, wdata_d;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q;

  logic [GW-1:0]         pick_idx;
  logic                  pick_vld;
  logic [GW-1:0]         rr_next;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_picker (
    .pending_i (req_read_en | req_write_en),
    .ptr_i     (rr_q),
    .idx_o     (pick_idx),
    .vld_o     (pick_vld)
  );

  assign rr_next = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = 1'b0;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          addr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[pick_idx*LINE_BITS +: LINE_BITS];
          // A requester asserting both enables is treated as a writeback.
          op_d    = req_write_en[pick_idx] ? OP_WRITE : OP_READ;
          rd_en_d = !req_write_en[pick_idx];
          wr_en_d = req_write_en[pick_idx];
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_en_d = (op_q == OP_READ);
        wr_en_d = (op_q == OP_WRITE);
        cnt_d   = cnt_q + 1'b1;
        if (mem_ready || (cnt_q == CW'(TIMEOUT))) begin
          ack_d[grant_q] = 1'b1;
          err_d   = !mem_ready;
          if (mem_ready && (op_q == OP_READ)) rdata_d = mem_read_data;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          rr_d    = rr_next;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (!mem_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign req_ack        = ack_q;
  assign req_rdata      = rdata_q;
  assign req_err        = err_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read_en    = rd_en_q;
  assign mem_write_en   = wr_en_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle pulse memory model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LB = 512;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LB-1:0] req_wdata;
  logic [NR-1:0]    req_read_en;
  logic [NR-1:0]    req_write_en;
  logic [NR-1:0]    req_ack;
  logic [LB-1:0]    req_rdata;
  logic             req_err;
  logic [AW-1:0]    mem_addr;
  logic [LB-1:0]    mem_write_data;
  logic             mem_read_en;
  logic             mem_write_en;
  logic [LB-1:0]    mem_read_data;
  logic             mem_ready;
  logic [0:0]       grant_id;
  logic             busy;

  logic             mem_auto;
  int               n_tests = 0;
  int               n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .LINE_SIZE  (64),
    .NUM_REQ    (NR),
    .TIMEOUT    (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_read_en    (req_read_en),
    .req_write_en   (req_write_en),
    .req_ack        (req_ack),
    .req_rdata      (req_rdata),
    .req_err        (req_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after seeing an enable, as a single-cycle pulse.
  initial mem_ready = 1'b0;
  always @(posedge clk) mem_ready <= mem_auto && (mem_read_en || mem_write_en) && !mem_ready;
  assign mem_read_data = {16{mem_addr[17:2], mem_addr[17:2]}};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_read_en = '0;
    req_write_en = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(output logic [NR-1:0] ack, output int cycles);
    logic seen;
    seen = 1'b0;
    ack = '0;
    cycles = 0;
    for (int k = 0; k < 60; k++) begin
      if (!seen) begin
        tick();
        cycles++;
        if (req_ack != '0) begin
          seen = 1'b1;
          ack = req_ack;
        end
      end
    end
  endtask

  task automatic wait_en(output int cycles);
    logic seen;
    seen = 1'b0;
    cycles = 0;
    for (int k = 0; k < 30; k++) begin
      if (!seen) begin
        tick();
        cycles++;
        seen = mem_read_en | mem_write_en;
      end
    end
  endtask

  initial begin
    logic [NR-1:0] ack;
    logic          any_ack;
    int            cyc;

    rst = 1'b1;
    mem_auto = 1'b1;
    req_addr = '0;
    req_wdata = '0;
    req_read_en = '0;
    req_write_en = '0;

    // Reset state
    do_reset();
    chk("rst_ack",   64'(req_ack), 64'h0);
    chk("rst_err",   64'(req_err), 64'h0);
    chk("rst_busy",  64'(busy), 64'h0);
    chk("rst_gnt",   64'(grant_id), 64'h0);
    chk("rst_rd",    64'(mem_read_en), 64'h0);
    chk("rst_wr",    64'(mem_write_en), 64'h0);
    chk("rst_rdata", req_rdata[63:0], 64'h0);

    // Single read with latency N+1 / N+3 / N+4
    req_addr[31:0] = 32'h0000_1000;
    req_read_en = 2'b01;
    tick();
    chk("rd_en",    64'(mem_read_en), 64'h1);
    chk("rd_wr_en", 64'(mem_write_en), 64'h0);
    chk("rd_addr",  64'(mem_addr), 64'h1000);
    chk("rd_busy",  64'(busy), 64'h1);
    wait_ack(ack, cyc);
    chk("rd_ack",   64'(ack), 64'h1);
    chk("rd_lat",   64'(cyc), 64'd2);
    chk("rd_data",  64'(req_rdata[31:0]), 64'h0400_0400);
    chk("rd_err",   64'(req_err), 64'h0);
    chk("rd_en_off", 64'(mem_read_en), 64'h0);
    req_read_en = '0;
    tick();
    chk("rd_idle",  64'(busy), 64'h0);
    chk("rd_ack_clr", 64'(req_ack), 64'h0);

    // Contention: read on req0 beats write on req1 from reset
    do_reset();
    req_addr[31:0]  = 32'h0000_5000;
    req_addr[63:32] = 32'h0000_7000;
    req_wdata[LB +: 32] = 32'hCCCC_CCCC;
    req_read_en  = 2'b01;
    req_write_en = 2'b10;
    tick();
    chk("ct_gnt0",  64'(grant_id), 64'h0);
    chk("ct_addr0", 64'(mem_addr), 64'h5000);
    wait_ack(ack, cyc);
    chk("ct_ack0",  64'(ack), 64'h1);
    chk("ct_data0", 64'(req_rdata[31:0]), 64'h1400_1400);
    req_read_en = '0;
    wait_en(cyc);
    chk("ct_gap",   64'(cyc), 64'd2);
    chk("ct_gnt1",  64'(grant_id), 64'h1);
    chk("ct_wr1",   64'(mem_write_en), 64'h1);
    chk("ct_addr1", 64'(mem_addr), 64'h7000);
    chk("ct_wdat1", 64'(mem_write_data[31:0]), 64'hCCCC_CCCC);
    wait_ack(ack, cyc);
    chk("ct_ack1",  64'(ack), 64'h2);
    chk("ct_rdata_hold", 64'(req_rdata[31:0]), 64'h1400_1400);
    req_write_en = '0;

    // Round-robin with both requesters held
    do_reset();
    req_addr[31:0]  = 32'h0000_0100;
    req_addr[63:32] = 32'h0000_0200;
    req_read_en = 2'b11;
    for (int t = 0; t < 6; t++) begin
      wait_ack(ack, cyc);
      chk($sformatf("rr_%0d", t), 64'(ack), (t % 2 == 0) ? 64'h1 : 64'h2);
    end
    req_read_en = '0;
    tick();
    tick();
    chk("rr_idle", 64'(busy), 64'h0);

    // Both enables on req1 -> write only
    req_addr[63:32] = 32'h0000_2000;
    req_read_en  = 2'b10;
    req_write_en = 2'b10;
    tick();
    chk("be_wr",   64'(mem_write_en), 64'h1);
    chk("be_rd",   64'(mem_read_en), 64'h0);
    chk("be_gnt",  64'(grant_id), 64'h1);
    chk("be_addr", 64'(mem_addr), 64'h2000);
    tick();
    chk("be_rd2",  64'(mem_read_en), 64'h0);
    wait_ack(ack, cyc);
    chk("be_ack",  64'(ack), 64'h2);
    req_read_en = '0;
    req_write_en = '0;
    tick();

    // Timeout with memory never responding
    mem_auto = 1'b0;
    req_addr[31:0] = 32'h0000_3000;
    req_read_en = 2'b01;
    tick();
    chk("to_issue", 64'(mem_read_en), 64'h1);
    wait_ack(ack, cyc);
    chk("to_lat",   64'(cyc), 64'd17);
    chk("to_ack",   64'(ack), 64'h1);
    chk("to_err",   64'(req_err), 64'h1);
    req_read_en = '0;
    tick();
    chk("to_err_clr", 64'(req_err), 64'h0);
    chk("to_idle",    64'(busy), 64'h0);

    // Reset while in ISSUE abandons the transaction
    req_addr[31:0] = 32'h0000_4000;
    req_read_en = 2'b01;
    tick();
    tick();
    chk("ri_issue", 64'(mem_read_en), 64'h1);
    rst = 1'b1;
    req_read_en = '0;
    tick();
    rst = 1'b0;
    mem_auto = 1'b1;
    chk("ri_rd_off", 64'(mem_read_en), 64'h0);
    chk("ri_busy",   64'(busy), 64'h0);
    any_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any_ack = any_ack | (req_ack != '0);
      tick();
    end
    chk("ri_no_ack", 64'(any_ack), 64'h0);
    req_addr[63:32] = 32'h0000_6000;
    req_write_en = 2'b10;
    tick();
    chk("ri_wr",   64'(mem_write_en), 64'h1);
    chk("ri_addr", 64'(mem_addr), 64'h6000);
    wait_ack(ack, cyc);
    chk("ri_ack",  64'(ack), 64'h2);
    chk("ri_lat",  64'(cyc), 64'd2);
    chk("ri_err",  64'(req_err), 64'h0);
    req_write_en = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
